cpu_control: RTL and testbench

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/instr_decoder.sv | 37 +++
 rtl/cpu_control.sv | 137 +++++++++++++
 tb/tb_cpu_control.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and encodings for the cpu_control FSM and decoder
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_COMPUTE,
    S_WRITE_REG
  } state_t;

  typedef enum logic [1:0] {
    NSEL_RN,
    NSEL_RD,
    NSEL_RM
  } nsel_t;

  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [2:0] OPC_MOV    = 3'b110;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_MVN    = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - IR field extraction, sign extension and register-index select
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  input  nsel_t       nsel_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  regnum_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o
);

  logic [2:0] rn, rd, rm;

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn       = ir_i[10:8];
  assign rd       = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm       = ir_i[2:0];

  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

  always_comb begin
    regnum_o = rn;
    unique case (nsel_i)
      NSEL_RN: regnum_o = rn;
      NSEL_RD: regnum_o = rd;
      NSEL_RM: regnum_o = rm;
      default: regnum_o = rn;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - instruction register and multi-cycle control FSM for the datapath
module cpu_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  nsel_t       nsel;
  logic [2:0]  opcode;
  logic [1:0]  op, sh;
  logic [2:0]  regnum;

  instr_decoder u_dec (
    .ir_i     (ir_q),
    .nsel_i   (nsel),
    .opcode_o (opcode),
    .op_o     (op),
    .sh_o     (sh),
    .regnum_o (regnum),
    .sximm5_o (sximm5),
    .sximm8_o (sximm8)
  );

  // IR only accepts new words while idle, so DECODE always sees the word loaded with s.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_WAIT: begin
        if (load) ir_d = in;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OPC_MOV && op == OP_MOV_IMM)
          state_d = S_WRITE_IMM;
        else if ((opcode == OPC_MOV && op == OP_MOV_REG) || (opcode == OPC_ALU && op == OP_MVN))
          state_d = S_GET_B;
        else if (opcode == OPC_ALU)
          state_d = S_GET_A;
        else
          state_d = S_WAIT;
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_COMPUTE;
      S_COMPUTE:   state_d = (opcode == OPC_ALU && op == OP_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    w     = (state_q == S_WAIT);
    nsel  = NSEL_RN;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    write = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = VSEL_MDATA;
    shift = 2'b00;
    ALUop = ALU_ADD;
    unique case (state_q)
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_COMPUTE: begin
        shift = sh;
        // MOV reg and MVN ignore operand A, so it is forced to zero via asel.
        if (opcode == OPC_MOV) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else if (op == OP_MVN) begin
          asel  = 1'b1;
          ALUop = ALU_MVN;
        end else begin
          ALUop = op;
        end
        if (opcode == OPC_ALU && op == OP_CMP) loads = 1'b1;
        else                                   loadc = 1'b1;
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      default: ;
    endcase
  end

  assign readnum  = regnum;
  assign writenum = regnum;

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - randomized self-checking bench for cpu_control
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, loada, loadb, loadc, loads, write, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [13:0] ctl;
    int          rn;
    int          wn;
  } step_t;

  step_t exp_q[$];

  cpu_control dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(bit wv, bit la, bit lb, bit lc, bit ls, bit wr, bit as,
                                     logic [1:0] vs, logic [1:0] sh, logic [1:0] alu);
    return {wv, la, lb, lc, ls, wr, as, 1'b0, vs, sh, alu};
  endfunction

  function automatic logic [13:0] snap();
    return {w, loada, loadb, loadc, loads, write, asel, bsel, vsel, shift, ALUop};
  endfunction

  function automatic logic [15:0] sx(logic [15:0] ir, int bits);
    int v;
    v = int'(ir) % (1 << bits);
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 16'(v);
  endfunction

  // Expected per-edge output sequence after s is sampled, straight from the instruction table.
  task automatic build(input logic [15:0] ir);
    int opc, op, rn, rd, sh, rm;
    opc = int'(ir) / 8192;
    op  = (int'(ir) / 2048) % 4;
    rn  = (int'(ir) / 256) % 8;
    rd  = (int'(ir) / 32) % 8;
    sh  = (int'(ir) / 8) % 4;
    rm  = int'(ir) % 8;
    exp_q.delete();
    exp_q.push_back('{mk(0,0,0,0,0,0,0,2'd0,2'd0,2'd0), -1, -1});
    if (opc == 6 && op == 2) begin
      exp_q.push_back('{mk(0,0,0,0,0,1,0,2'd1,2'd0,2'd0), -1, rn});
    end else if ((opc == 6 && op == 0) || (opc == 5 && op == 3)) begin
      exp_q.push_back('{mk(0,0,1,0,0,0,0,2'd0,2'd0,2'd0), rm, -1});
      exp_q.push_back('{mk(0,0,0,1,0,0,1,2'd0,2'(sh),(opc == 6) ? 2'd0 : 2'd3), -1, -1});
      exp_q.push_back('{mk(0,0,0,0,0,1,0,2'd3,2'd0,2'd0), -1, rd});
    end else if (opc == 5) begin
      exp_q.push_back('{mk(0,1,0,0,0,0,0,2'd0,2'd0,2'd0), rn, -1});
      exp_q.push_back('{mk(0,0,1,0,0,0,0,2'd0,2'd0,2'd0), rm, -1});
      if (op == 1)
        exp_q.push_back('{mk(0,0,0,0,1,0,0,2'd0,2'(sh),2'd1), -1, -1});
      else begin
        exp_q.push_back('{mk(0,0,0,1,0,0,0,2'd0,2'(sh),2'(op)), -1, -1});
        exp_q.push_back('{mk(0,0,0,0,0,1,0,2'd3,2'd0,2'd0), -1, rd});
      end
    end
    exp_q.push_back('{mk(1,0,0,0,0,0,0,2'd0,2'd0,2'd0), -1, -1});
  endtask

  task automatic test_reset();
    reset = 1'b1; s = 1'b1; load = 1'b1; in = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; s = 1'b0; load = 1'b0;
    total++;
    if (snap() !== mk(1,0,0,0,0,0,0,2'd0,2'd0,2'd0) || sximm5 !== 16'h0 || sximm8 !== 16'h0) begin
      bad++;
      $display("FAIL reset: got ctl=%b x5=%h x8=%h, want ctl=%b x5=0000 x8=0000",
               snap(), sximm5, sximm8, mk(1,0,0,0,0,0,0,2'd0,2'd0,2'd0));
    end
  endtask

  task automatic test_directed();
    logic [15:0] tbl [6];
    tbl = '{16'hD007, 16'hA148, 16'hA801, 16'hB860, 16'hE000, 16'hD0F0};
    foreach (tbl[i]) begin
      build(tbl[i]);
      in = tbl[i]; load = 1'b1; s = 1'b1;
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        total++;
        if (snap() !== exp_q[k].ctl
            || (exp_q[k].rn >= 0 && readnum !== 3'(exp_q[k].rn))
            || (exp_q[k].wn >= 0 && writenum !== 3'(exp_q[k].wn))
            || sximm5 !== sx(tbl[i], 5) || sximm8 !== sx(tbl[i], 8)) begin
          bad++;
          $display("FAIL directed ir=%h edge=%0d: got ctl=%b rn=%0d wn=%0d x5=%h x8=%h, want ctl=%b rn=%0d wn=%0d x5=%h x8=%h",
                   tbl[i], k + 1, snap(), readnum, writenum, sximm5, sximm8,
                   exp_q[k].ctl, exp_q[k].rn, exp_q[k].wn, sx(tbl[i], 5), sx(tbl[i], 8));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ir;
    for (int n = 0; n < 60; n++) begin
      ir = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ir[15:13] = 3'b101;
        1: ir[15:13] = 3'b110;
        2: ir[15:11] = 5'b10101;
        default: ;
      endcase
      build(ir);
      in = ir; load = 1'b1; s = 1'b1;
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        total++;
        if (snap() !== exp_q[k].ctl
            || (exp_q[k].rn >= 0 && readnum !== 3'(exp_q[k].rn))
            || (exp_q[k].wn >= 0 && writenum !== 3'(exp_q[k].wn))
            || sximm5 !== sx(ir, 5) || sximm8 !== sx(ir, 8)) begin
          bad++;
          $display("FAIL random ir=%h edge=%0d: got ctl=%b rn=%0d wn=%0d x5=%h x8=%h, want ctl=%b rn=%0d wn=%0d x5=%h x8=%h",
                   ir, k + 1, snap(), readnum, writenum, sximm5, sximm8,
                   exp_q[k].ctl, exp_q[k].rn, exp_q[k].wn, sx(ir, 5), sx(ir, 8));
        end
        if (k <= exp_q.size() - 2) begin
          s    = 1'($urandom);
          load = 1'($urandom);
          in   = 16'($urandom);
        end
      end
      s = 1'b0; load = 1'b0;
    end
  endtask

  task automatic test_load_only();
    logic [15:0] v;
    for (int n = 0; n < 4; n++) begin
      v = 16'($urandom);
      in = v; load = 1'b1; s = 1'b0;
      @(posedge clk); #1;
      load = 1'b0;
      total++;
      if (w !== 1'b1 || sximm8 !== sx(v, 8) || sximm5 !== sx(v, 5)) begin
        bad++;
        $display("FAIL load_only: got w=%b x5=%h x8=%h, want w=1 x5=%h x8=%h",
                 w, sximm5, sximm8, sx(v, 5), sx(v, 8));
      end
    end
  endtask

  task automatic test_reset_mid();
    in = 16'hA148; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (loadc !== 1'b1 || shift !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_compute: got loadc=%b shift=%b, want loadc=1 shift=01", loadc, shift);
    end
    reset = 1'b1; s = 1'b1; load = 1'b1; in = 16'hFFFF;
    @(posedge clk); #1;
    reset = 1'b0; s = 1'b0; load = 1'b0;
    total++;
    if (snap() !== mk(1,0,0,0,0,0,0,2'd0,2'd0,2'd0) || sximm5 !== 16'h0 || sximm8 !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: got ctl=%b x5=%h x8=%h, want ctl=%b x5=0000 x8=0000",
               snap(), sximm5, sximm8, mk(1,0,0,0,0,0,0,2'd0,2'd0,2'd0));
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (write !== 1'b0 || w !== 1'b1) begin
        bad++;
        $display("FAIL reset_mid_idle edge=%0d: got write=%b w=%b, want write=0 w=1", k, write, w);
      end
    end
  endtask

  initial begin
    reset = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0;
    test_reset();
    test_directed();
    test_load_only();
    test_back_to_back();
    test_reset_mid();
    test_directed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
